// File: rtl/float_mult_pipe.sv
// float_mult_pipe
// Three-stage pipelined multiplier for the {sign, exponent, mantissa} word
// format used in the neural processor datapath. Exponent field 0 encodes zero
// (no denormals), the largest exponent is an ordinary finite value, results
// saturate on overflow and flush to zero on underflow. A single clock enable
// (ready_i) stalls the whole pipe so the output word is held until taken.
//
//   S1: sign, raw biased exponent, zero flag, full significand product
//   S2: normalise the product and round (or truncate) the mantissa
//   S3: range check, pack, output register

module float_mult_pipe #(
   parameter int EXP_W    = 5,
   parameter int MAN_W    = 6,
   parameter int BIAS     = 2**(EXP_W-1) - 1,
   parameter bit ROUND_EN = 1'b1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   valid_i,
   output logic                   ready_o,
   input  logic [EXP_W+MAN_W:0]   data_1_i,
   input  logic [EXP_W+MAN_W:0]   data_2_i,
   output logic                   valid_o,
   input  logic                   ready_i,
   output logic [EXP_W+MAN_W:0]   data_mult_o,
   output logic                   ovf_o,
   output logic                   unf_o
);

   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int SW = MAN_W + 1;          // significand width with hidden one
   localparam int PW = 2 * SW;             // full product width
   // Signed exponent working width: one bit wider than the minimum so that the
   // normalise and rounding increments can never wrap, even with a small BIAS.
   localparam int EW = EXP_W + 3;

   localparam logic        [EW-1:0] BIAS_C  = EW'(BIAS);
   localparam logic signed [EW-1:0] EXP_MAX = EW'(2**EXP_W - 1);
   localparam logic signed [EW-1:0] EXP_ONE = EW'(1);
   localparam logic signed [EW-1:0] EXP_INC = EW'(1);

   // ------------------------------------------------------------------
   // Operand field split (combinational, feeds S1)
   // ------------------------------------------------------------------
   logic                 w_a_sign;
   logic                 w_b_sign;
   logic [EXP_W-1:0]     w_a_exp;
   logic [EXP_W-1:0]     w_b_exp;
   logic [MAN_W-1:0]     w_a_man;
   logic [MAN_W-1:0]     w_b_man;
   logic                 w_zero;
   logic signed [EW-1:0] w_exp_raw;
   logic [PW-1:0]        w_prod;

   assign w_a_sign = data_1_i[W-1];
   assign w_b_sign = data_2_i[W-1];
   assign w_a_exp  = data_1_i[W-2 -: EXP_W];
   assign w_b_exp  = data_2_i[W-2 -: EXP_W];
   assign w_a_man  = data_1_i[MAN_W-1:0];
   assign w_b_man  = data_2_i[MAN_W-1:0];

   // Any operand with a zero exponent field forces a zero product.
   assign w_zero    = (w_a_exp == {EXP_W{1'b0}}) | (w_b_exp == {EXP_W{1'b0}});
   assign w_exp_raw = EW'(w_a_exp) + EW'(w_b_exp) - BIAS_C;
   assign w_prod    = PW'({1'b1, w_a_man}) * PW'({1'b1, w_b_man});

   // The downstream handshake is passed straight through: the pipe advances
   // exactly when the consumer can take a result.
   assign ready_o = ready_i;

   // ------------------------------------------------------------------
   // Stage 1 registers
   // ------------------------------------------------------------------
   logic                 r_s1_valid;
   logic                 r_s1_sign;
   logic                 r_s1_zero;
   logic signed [EW-1:0] r_s1_exp;
   logic [PW-1:0]        r_s1_prod;

   // Stage 1: capture sign, raw exponent, zero flag and significand product
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_s1_valid <= 1'b0;
         r_s1_sign  <= 1'b0;
         r_s1_zero  <= 1'b0;
         r_s1_exp   <= {EW{1'b0}};
         r_s1_prod  <= {PW{1'b0}};
      end else if (ready_i) begin
         r_s1_valid <= valid_i;
         r_s1_sign  <= w_a_sign ^ w_b_sign;
         r_s1_zero  <= w_zero;
         r_s1_exp   <= w_exp_raw;
         r_s1_prod  <= w_prod;
      end
   end

   // ------------------------------------------------------------------
   // Stage 2 combinational: normalise and round
   // ------------------------------------------------------------------
   // The product of two significands in [1,2) lies in [1,4), so its top bit
   // or the one below it is always set. w_norm drops that leading one and
   // keeps everything beneath it aligned to a fixed position.
   logic [PW-2:0]        w_norm;
   logic signed [EW-1:0] w_exp_norm;
   logic [MAN_W-1:0]     w_man_trunc;
   logic                 w_guard;
   logic                 w_sticky;
   logic                 w_round_up;
   logic [MAN_W:0]       w_man_sum;
   logic [MAN_W-1:0]     w_man_rnd;
   logic signed [EW-1:0] w_exp_rnd;

   // Stage 2 logic: one-bit normalise, guard/sticky extraction, RNE increment
   always_comb begin
      w_norm     = {(PW-1){1'b0}};
      w_exp_norm = r_s1_exp;
      if (r_s1_prod[PW-1]) begin
         w_norm     = r_s1_prod[PW-2:0];
         w_exp_norm = r_s1_exp + EXP_INC;
      end else begin
         w_norm     = {r_s1_prod[PW-3:0], 1'b0};
         w_exp_norm = r_s1_exp;
      end

      w_man_trunc = w_norm[PW-2 -: MAN_W];
      w_guard     = w_norm[PW-2-MAN_W];
      w_sticky    = |w_norm[PW-3-MAN_W:0];

      if (ROUND_EN) begin
         w_round_up = w_guard & (w_sticky | w_man_trunc[0]);
      end else begin
         w_round_up = 1'b0;
      end

      // A carry out of the mantissa leaves the stored bits all zero, which is
      // exactly the renormalised mantissa; only the exponent needs bumping.
      w_man_sum = {1'b0, w_man_trunc} + {{MAN_W{1'b0}}, w_round_up};
      w_man_rnd = w_man_sum[MAN_W-1:0];
      if (w_man_sum[MAN_W]) begin
         w_exp_rnd = w_exp_norm + EXP_INC;
      end else begin
         w_exp_rnd = w_exp_norm;
      end
   end

   // ------------------------------------------------------------------
   // Stage 2 registers
   // ------------------------------------------------------------------
   logic                 r_s2_valid;
   logic                 r_s2_sign;
   logic                 r_s2_zero;
   logic signed [EW-1:0] r_s2_exp;
   logic [MAN_W-1:0]     r_s2_man;

   // Stage 2: hold the normalised, rounded sign/exponent/mantissa
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_s2_valid <= 1'b0;
         r_s2_sign  <= 1'b0;
         r_s2_zero  <= 1'b0;
         r_s2_exp   <= {EW{1'b0}};
         r_s2_man   <= {MAN_W{1'b0}};
      end else if (ready_i) begin
         r_s2_valid <= r_s1_valid;
         r_s2_sign  <= r_s1_sign;
         r_s2_zero  <= r_s1_zero;
         r_s2_exp   <= w_exp_rnd;
         r_s2_man   <= w_man_rnd;
      end
   end

   // ------------------------------------------------------------------
   // Stage 3 combinational: range check and pack
   // ------------------------------------------------------------------
   logic [W-1:0] w_out_word;
   logic         w_out_ovf;
   logic         w_out_unf;

   // Stage 3 logic: zero, saturate, flush or pack; bubbles produce a clean zero
   always_comb begin
      w_out_word = {W{1'b0}};
      w_out_ovf  = 1'b0;
      w_out_unf  = 1'b0;
      if (!r_s2_valid || r_s2_zero) begin
         w_out_word = {W{1'b0}};
         w_out_ovf  = 1'b0;
         w_out_unf  = 1'b0;
      end else if (r_s2_exp > EXP_MAX) begin
         w_out_word = {r_s2_sign, {(W-1){1'b1}}};
         w_out_ovf  = 1'b1;
         w_out_unf  = 1'b0;
      end else if (r_s2_exp < EXP_ONE) begin
         w_out_word = {W{1'b0}};
         w_out_ovf  = 1'b0;
         w_out_unf  = 1'b1;
      end else begin
         w_out_word = {r_s2_sign, r_s2_exp[EXP_W-1:0], r_s2_man};
         w_out_ovf  = 1'b0;
         w_out_unf  = 1'b0;
      end
   end

   // Stage 3: registered outputs, frozen while the consumer stalls
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_o     <= 1'b0;
         data_mult_o <= {W{1'b0}};
         ovf_o       <= 1'b0;
         unf_o       <= 1'b0;
      end else if (ready_i) begin
         valid_o     <= r_s2_valid;
         data_mult_o <= w_out_word;
         ovf_o       <= w_out_ovf;
         unf_o       <= w_out_unf;
      end
   end

endmodule

// File: tb/tb_float_mult_pipe.sv
// Bench for float_mult_pipe: three instances (default RNE, default truncate,
// EXP_W=8/MAN_W=10 RNE) share clock, reset and handshake. A value-level
// reference (exact integer product, remainder-vs-half rounding) feeds a
// three-deep delay line per instance that advances only on enabled edges.

module tb_float_mult_pipe;

   typedef struct packed {
      logic        v;     // result expected valid
      logic        chk;   // check data/flags even when not valid (reset state)
      logic [31:0] word;
      logic        ovf;
      logic        unf;
   } exp_t;

   localparam exp_t RST_E = '{v: 1'b0, chk: 1'b1, word: 32'd0, ovf: 1'b0, unf: 1'b0};
   localparam exp_t BUB_E = '{v: 1'b0, chk: 1'b0, word: 32'd0, ovf: 1'b0, unf: 1'b0};

   logic        clk      = 1'b0;
   logic        rst      = 1'b1;
   logic        valid_in = 1'b0;
   logic        ready_in = 1'b1;
   logic [11:0] a12      = 12'd0;
   logic [11:0] b12      = 12'd0;
   logic [18:0] a19      = 19'd0;
   logic [18:0] b19      = 19'd0;

   logic        rdy_n, vo_n, ovf_n, unf_n;
   logic [11:0] dat_n;
   logic        rdy_t, vo_t, ovf_t, unf_t;
   logic [11:0] dat_t;
   logic        rdy_w, vo_w, ovf_w, unf_w;
   logic [18:0] dat_w;

   int   n_checks = 0;
   int   n_pass   = 0;
   bit   started  = 1'b0;
   exp_t pipe [3][3];

   always #5 clk = ~clk;

   float_mult_pipe u_dut (
      .clk_i(clk), .rst_i(rst), .valid_i(valid_in), .ready_o(rdy_n),
      .data_1_i(a12), .data_2_i(b12), .valid_o(vo_n), .ready_i(ready_in),
      .data_mult_o(dat_n), .ovf_o(ovf_n), .unf_o(unf_n));

   float_mult_pipe #(.ROUND_EN(1'b0)) u_trunc (
      .clk_i(clk), .rst_i(rst), .valid_i(valid_in), .ready_o(rdy_t),
      .data_1_i(a12), .data_2_i(b12), .valid_o(vo_t), .ready_i(ready_in),
      .data_mult_o(dat_t), .ovf_o(ovf_t), .unf_o(unf_t));

   float_mult_pipe #(.EXP_W(8), .MAN_W(10)) u_wide (
      .clk_i(clk), .rst_i(rst), .valid_i(valid_in), .ready_o(rdy_w),
      .data_1_i(a19), .data_2_i(b19), .valid_o(vo_w), .ready_i(ready_in),
      .data_mult_o(dat_w), .ovf_o(ovf_w), .unf_o(unf_w));

   // Value-level reference: exact product rounded to mw+1 significant bits.
   function automatic exp_t ref_mul(input int a, input int b, input int ew,
                                    input int mw, input int bias, input bit rnd);
      exp_t   r;
      int     ea, eb, e, len, sh;
      longint ma, mb, p, q, rem, half;
      bit     sgn;
      r     = BUB_E;
      r.v   = 1'b1;
      r.chk = 1'b1;
      ea  = (a >> mw) & ((1 << ew) - 1);
      eb  = (b >> mw) & ((1 << ew) - 1);
      ma  = longint'(a & ((1 << mw) - 1)) + (longint'(1) << mw);
      mb  = longint'(b & ((1 << mw) - 1)) + (longint'(1) << mw);
      sgn = (((a >> (ew + mw)) & 1) != ((b >> (ew + mw)) & 1));
      if (ea == 0 || eb == 0) begin
         return r;
      end
      p    = ma * mb;
      len  = (p >= (longint'(1) << (2 * mw + 1))) ? 2 * mw + 2 : 2 * mw + 1;
      sh   = len - (mw + 1);
      q    = p >> sh;
      rem  = p - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rnd && (rem > half || (rem == half && (q % 2) == 1))) q = q + 1;
      e = ea + eb - bias + (len - (2 * mw + 1));
      if (q == (longint'(1) << (mw + 1))) begin
         q = q >> 1;
         e = e + 1;
      end
      if (e > (1 << ew) - 1) begin
         r.ovf  = 1'b1;
         r.word = 32'((int'(sgn) << (ew + mw)) | ((1 << (ew + mw)) - 1));
      end else if (e <= 0) begin
         r.unf  = 1'b1;
         r.word = 32'd0;
      end else begin
         r.word = 32'((int'(sgn) << (ew + mw)) | (e << mw) | int'(q - (longint'(1) << mw)));
      end
      return r;
   endfunction

   function automatic exp_t next_e(input int k);
      if (k == 2) return ref_mul(int'(a19), int'(b19), 8, 10, 127, 1'b1);
      else        return ref_mul(int'(a12), int'(b12), 5, 6, 15, (k == 0));
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic cmp_inst(input string tag, input logic rdy, input logic v,
                           input logic [31:0] d, input logic o, input logic u,
                           input exp_t e);
      check({tag, " ready_o"}, 32'(rdy), 32'(ready_in));
      check({tag, " valid_o"}, 32'(v), 32'(e.v));
      if (e.v || e.chk) begin
         check({tag, " data"}, d, e.word);
         check({tag, " ovf_o"}, 32'(o), 32'(e.ovf));
         check({tag, " unf_o"}, 32'(u), 32'(e.unf));
      end
   endtask

   // Reference pipeline: three enabled stages per instance, cleared by reset
   always @(posedge clk) begin
      started <= 1'b1;
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            for (int s = 0; s < 3; s++) pipe[k][s] <= RST_E;
         end else if (ready_in) begin
            pipe[k][2] <= pipe[k][1];
            pipe[k][1] <= pipe[k][0];
            pipe[k][0] <= valid_in ? next_e(k) : BUB_E;
         end
      end
   end

   // Compare every instance against the reference on the falling edge
   always @(negedge clk) begin
      if (started) begin
         cmp_inst("rne12", rdy_n, vo_n, {20'd0, dat_n}, ovf_n, unf_n, pipe[0][2]);
         cmp_inst("trn12", rdy_t, vo_t, {20'd0, dat_t}, ovf_t, unf_t, pipe[1][2]);
         cmp_inst("rne19", rdy_w, vo_w, {13'd0, dat_w}, ovf_w, unf_w, pipe[2][2]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_ops();
      a12 = 12'($urandom);
      b12 = 12'($urandom);
      a19 = 19'($urandom);
      b19 = 19'($urandom);
   endtask

   task automatic send(input logic [11:0] a, input logic [11:0] b);
      rand_ops();
      valid_in = 1'b1;
      a12      = a;
      b12      = b;
      tick();
   endtask

   task automatic idle(input int n);
      valid_in = 1'b0;
      repeat (n) tick();
   endtask

   task automatic pin(input string name, input exp_t got, input logic [31:0] w,
                      input logic o, input logic u);
      check({name, " word"}, got.word, w);
      check({name, " flags"}, {30'd0, got.ovf, got.unf}, {30'd0, o, u});
   endtask

   initial begin
      // Hand-computed anchors for the reference itself
      pin("model 1.5*1.5",   ref_mul(32'h3E0, 32'h3E0, 5, 6, 15, 1'b1), 32'h408, 1'b0, 1'b0);
      pin("model 2*-2",      ref_mul(32'h400, 32'hC00, 5, 6, 15, 1'b1), 32'hC40, 1'b0, 1'b0);
      pin("model tie rne",   ref_mul(32'h3C1, 32'h3E0, 5, 6, 15, 1'b1), 32'h3E2, 1'b0, 1'b0);
      pin("model tie trunc", ref_mul(32'h3C1, 32'h3E0, 5, 6, 15, 1'b0), 32'h3E1, 1'b0, 1'b0);
      pin("model ovf",       ref_mul(32'h7C0, 32'h400, 5, 6, 15, 1'b1), 32'h7FF, 1'b1, 1'b0);
      pin("model unf",       ref_mul(32'h040, 32'h040, 5, 6, 15, 1'b1), 32'h000, 1'b0, 1'b1);
      pin("model zero",      ref_mul(32'h000, 32'hBC0, 5, 6, 15, 1'b1), 32'h000, 1'b0, 1'b0);
      pin("model wide 1*1",  ref_mul(32'h1FC00, 32'h1FC00, 8, 10, 127, 1'b1), 32'h1FC00, 1'b0, 1'b0);
      pin("model wide lsb",  ref_mul(32'h1FC01, 32'h1FC01, 8, 10, 127, 1'b1), 32'h1FC02, 1'b0, 1'b0);

      // Reset, then release
      rst      = 1'b1;
      valid_in = 1'b0;
      ready_in = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      idle(1);

      // Directed back-to-back operands
      send(12'h3E0, 12'h3E0);
      send(12'h400, 12'hC00);
      send(12'h3C1, 12'h3E0);
      send(12'h7C0, 12'h400);
      send(12'h040, 12'h040);
      send(12'h000, 12'hBC0);
      idle(4);

      // Stream with ready_i low for 4 cycles mid-stream (inputs ignored then)
      for (int i = 0; i < 9; i++) begin
         rand_ops();
         valid_in = 1'b1;
         ready_in = !(i >= 2 && i < 6);
         tick();
      end
      ready_in = 1'b1;
      idle(4);

      // Reset with three operations in flight
      for (int i = 0; i < 3; i++) begin
         rand_ops();
         valid_in = 1'b1;
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle(5);

      // Reset while stalled must still clear the pipe
      for (int i = 0; i < 2; i++) begin
         rand_ops();
         valid_in = 1'b1;
         tick();
      end
      ready_in = 1'b0;
      rst      = 1'b1;
      tick();
      rst      = 1'b0;
      ready_in = 1'b1;
      idle(4);

      // Random sweep with random bubbles and stalls
      for (int i = 0; i < 15000; i++) begin
         rand_ops();
         valid_in = ($urandom_range(0, 9) < 8);
         ready_in = ($urandom_range(0, 9) < 8);
         tick();
      end
      ready_in = 1'b1;
      idle(6);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
